// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit and the datapath it drives:
// state encoding, opcodes, mux select codes and the opcode-decode bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  typedef struct packed {
    logic [2:0] imm_src;
    logic       is_load;
    logic       is_store;
    logic       is_rtype;
    logic       is_itype;
    logic       is_jal;
    logic       is_beq;
    logic       legal;
  } opdec_t;

endpackage

// File: rtl/multicycle_ctrl_opdec.sv
// Combinational opcode classifier: instruction class flags plus immediate format.
module mc_opdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output opdec_t     dec
);

  // Classify the opcode; anything unrecognised leaves legal low.
  always_comb begin
    dec         = '0;
    dec.imm_src = IMM_I;
    case (op)
      OP_LW:    begin dec.is_load  = 1'b1; dec.legal = 1'b1; end
      OP_SW:    begin dec.is_store = 1'b1; dec.legal = 1'b1; dec.imm_src = IMM_S; end
      OP_RTYPE: begin dec.is_rtype = 1'b1; dec.legal = 1'b1; end
      OP_ITYPE: begin dec.is_itype = 1'b1; dec.legal = 1'b1; end
      OP_JAL:   begin dec.is_jal   = 1'b1; dec.legal = 1'b1; dec.imm_src = IMM_J; end
      OP_BEQ:   begin dec.is_beq   = 1'b1; dec.legal = 1'b1; dec.imm_src = IMM_B; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle RV32I datapath with optional memory-ready
// waits, sticky illegal-opcode trap and a wrapping retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 0,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             mem_done;
  logic             pc_update;
  logic             branch;
  logic             retire;
  opdec_t           dec;

  mc_opdec u_opdec (
    .op  (op),
    .dec (dec)
  );

  // Without the handshake every memory access finishes in its first cycle.
  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  // State, counter and trap flag; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, Moore control decode and bookkeeping updates.
  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    RegWrite  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_done;
        pc_update = mem_done;
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (!dec.legal)                       state_d = S_TRAP;
        else if (dec.is_load || dec.is_store) state_d = S_MEMADR;
        else if (dec.is_rtype)                state_d = S_EXECUTER;
        else if (dec.is_itype)                state_d = S_EXECUTEI;
        else if (dec.is_jal)                  state_d = S_JAL;
        else                                  state_d = S_BEQ;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = dec.is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // An instruction retires on the edge that returns to FETCH from its last state.
    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
              (state_q == S_ALUWB) || (state_q == S_BEQ));
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    illegal_d = illegal_q || (state_d == S_TRAP);
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign ImmSrc  = dec.imm_src;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: an instruction-level phase-queue model predicts every
// cycle's control outputs; a monitor pops and compares on each falling edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXR, P_EXI, P_ALUWB, P_JAL, P_BEQ, P_TRAP} phase_e;

  typedef struct packed {
    logic        pcw;
    logic        adr;
    logic        mw;
    logic        irw;
    logic [1:0]  rs;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  aop;
    logic [2:0]  imm;
    logic        rw;
    logic        ill;
    logic [31:0] ret;
  } ctl_t;

  typedef struct {
    phase_e     ph;
    logic [6:0] op;
    bit         last;
  } step_t;

  typedef struct {
    ctl_t  exp;
    ctl_t  mask;
    string name;
    bit    timeout;
  } item_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, aop0;
  logic [2:0] imm0;
  logic [31:0] ret0;
  logic       pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, aop1;
  logic [2:0] imm1;
  logic [3:0] ret1;

  ctl_t act0, act1;
  assign act0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, aop0, imm0, rw0, ill0, ret0};
  assign act1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, aop1, imm1, rw1, ill1, 28'd0, ret1};

  multicycle_ctrl #(.MEM_HANDSHAKE(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0),
    .ImmSrc(imm0), .RegWrite(rw0), .illegal(ill0), .retired(ret0)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1),
    .ImmSrc(imm1), .RegWrite(rw1), .illegal(ill1), .retired(ret1)
  );

  initial forever #5 clk = ~clk;

  // Model and scoreboard state
  step_t       prog[$];
  item_t       sb_q[$];
  bit          sel = 1'b0;
  bit          hs = 1'b0;
  int          cnt_w = 32;
  int unsigned retired_m = 0;
  bit          ill_m = 1'b0;
  int          wait_pct = 0;
  int          stall_left = 0;
  phase_e      stall_ph = P_FETCH;
  int          zero_mode = -1;
  int          total = 0;
  int          bad = 0;
  event        mon_ev;

  function automatic logic [2:0] imm_exp(input logic [6:0] o);
    case (o)
      SW:      return 3'b001;
      BQ:      return 3'b010;
      JL:      return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit waitable(input phase_e ph);
    return (ph == P_FETCH) || (ph == P_MEMREAD) || (ph == P_MEMWRITE);
  endfunction

  // Control outputs straight from the per-state output table.
  function automatic ctl_t exp_out(input phase_e ph, input bit ok, input logic z,
                                   input logic [6:0] o, input bit ill, input int unsigned cnt);
    ctl_t e;
    e = '0;
    case (ph)
      P_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = ok; e.pcw = ok; end
      P_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      P_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      P_MEMREAD:  begin e.adr = 1'b1; end
      P_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
      P_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      P_EXR:      begin e.sa = 2'b10; e.aop = 2'b10; end
      P_EXI:      begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      P_ALUWB:    begin e.rw = 1'b1; end
      P_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      P_BEQ:      begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
      default:    ;
    endcase
    e.imm = imm_exp(o);
    e.ill = ill;
    e.ret = (cnt_w >= 32) ? cnt : (cnt % (32'd1 << cnt_w));
    return e;
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return LW;
      1:       return SW;
      2:       return RT;
      3:       return IT;
      4:       return JL;
      default: return BQ;
    endcase
  endfunction

  // Append one instruction as its fetch plus class-specific state sequence.
  task automatic add_instr(input logic [6:0] o);
    phase_e seq[$];
    step_t  s;
    seq = {P_FETCH, P_DECODE};
    case (o)
      LW:      begin seq.push_back(P_MEMADR); seq.push_back(P_MEMREAD); seq.push_back(P_MEMWB); end
      SW:      begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWRITE); end
      RT:      begin seq.push_back(P_EXR); seq.push_back(P_ALUWB); end
      IT:      begin seq.push_back(P_EXI); seq.push_back(P_ALUWB); end
      JL:      begin seq.push_back(P_JAL); seq.push_back(P_ALUWB); end
      BQ:      seq.push_back(P_BEQ);
      default: seq.push_back(P_TRAP);
    endcase
    foreach (seq[i]) begin
      s.ph   = seq[i];
      s.op   = o;
      s.last = (i == seq.size() - 1);
      prog.push_back(s);
    end
  endtask

  // Drive one cycle, queue its expectation, then advance the model past the edge.
  task automatic run_cycle();
    phase_e ph;
    bit     ok;
    item_t  it;
    step_t  s;
    ph = (prog.size() > 0) ? prog[0].ph : P_FETCH;
    Zero = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
    if (stall_left > 0 && ph == stall_ph) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = ($urandom_range(0, 99) >= wait_pct);
    end
    ok = !hs || mem_ready;
    if (ph == P_TRAP) ill_m = 1'b1;
    it.exp     = exp_out(ph, ok, Zero, op, ill_m, retired_m);
    it.mask    = '1;
    it.name    = ph.name();
    it.timeout = 1'b0;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    if (reset_n && prog.size() > 0 && ph != P_TRAP && (ok || !waitable(ph))) begin
      s = prog.pop_front();
      if (s.ph == P_FETCH) op = s.op;
      if (s.last) retired_m++;
    end
  endtask

  task automatic run_prog();
    int guard;
    item_t it;
    guard = 0;
    while (prog.size() > 0 && guard < 2000) begin
      run_cycle();
      guard++;
    end
    if (prog.size() > 0) begin
      it.exp = '0; it.mask = '0; it.name = "prog_timeout"; it.timeout = 1'b1;
      sb_q.push_back(it);
      ->mon_ev;
      #1;
      prog.delete();
    end
  endtask

  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    prog.delete();
    retired_m = 0;
    ill_m     = 1'b0;
    repeat (n) run_cycle();
    reset_n   = 1'b1;
  endtask

  // Immediate (non-clocked) check of selected fields on dut1.
  task automatic async_check(input string name, input logic mw_exp);
    item_t it;
    it.exp     = '0;
    it.exp.mw  = mw_exp;
    it.mask    = '0;
    it.mask.mw = 1'b1;
    it.mask.ret = '1;
    it.exp.ret = (mw_exp) ? (retired_m % 16) : 32'd0;
    it.name    = name;
    it.timeout = 1'b0;
    sb_q.push_back(it);
    ->mon_ev;
    #1;
  endtask

  // Monitor: pops every pending expectation at each falling edge (or on request).
  initial begin
    item_t it;
    ctl_t  a;
    forever begin
      @(negedge clk or mon_ev);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        a  = sel ? act1 : act0;
        total++;
        if (it.timeout) begin
          bad++;
          $display("FAIL %s: model program did not drain within cycle budget", it.name);
        end else if ((a & it.mask) !== (it.exp & it.mask)) begin
          bad++;
          $display("FAIL %s dut%0d: got %h expected %h", it.name, sel,
                   a & it.mask, it.exp & it.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // No handshake, 32-bit counter
    sel = 1'b0; hs = 1'b0; cnt_w = 32; wait_pct = 30;
    @(posedge clk);
    #1;
    do_reset(2);
    add_instr(LW);
    run_prog();
    zero_mode = 1; add_instr(BQ); run_prog();
    zero_mode = 0; add_instr(BQ); run_prog();
    zero_mode = -1;
    repeat (40) add_instr(rand_op());
    run_prog();
    add_instr(BAD);
    repeat (14) run_cycle();
    do_reset(2);
    add_instr(RT);
    add_instr(SW);
    run_prog();

    // Handshake, 4-bit counter
    sel = 1'b1; hs = 1'b1; cnt_w = 4; wait_pct = 25;
    do_reset(2);
    repeat (40) add_instr(rand_op());
    run_prog();
    wait_pct = 0;
    stall_ph = P_MEMWRITE; stall_left = 3; add_instr(SW); run_prog();
    stall_ph = P_FETCH;    stall_left = 2; add_instr(IT); run_prog();
    stall_ph = P_MEMREAD;  stall_left = 2; add_instr(LW); run_prog();
    repeat (16) add_instr(RT);
    run_prog();
    if (retired_m % 16 == 0) begin
      add_instr(JL);
      run_prog();
    end

    // Asynchronous reset while a store is waiting in MEMWRITE
    stall_ph = P_MEMWRITE; stall_left = 100;
    add_instr(SW);
    guard = 0;
    while (prog[0].ph != P_MEMWRITE && guard < 50) begin
      run_cycle();
      guard++;
    end
    mem_ready = 1'b0;
    #1;
    async_check("memwrite_before_reset", 1'b1);
    reset_n = 1'b0;
    #1;
    async_check("memwrite_async_reset", 1'b0);
    stall_left = 0;
    @(posedge clk);
    #1;
    do_reset(1);
    add_instr(LW);
    add_instr(BQ);
    run_prog();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
